// File: rtl/irq_front_ctrl_if.sv
// Sequencer-side handshake of the interrupt front-end.
// The sequencer drives ack/eoi and sees the single prioritized request.
interface irq_front_ctrl_if #(
    parameter int N_IRQ = 8
);
    localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic             ack;
    logic             eoi;
    logic [N_IRQ-1:0] irq_req;
    logic             irq_valid;
    logic [IDW-1:0]   irq_id;

    modport master (
        output ack, eoi,
        input  irq_req, irq_valid, irq_id
    );

    modport slave (
        input  ack, eoi,
        output irq_req, irq_valid, irq_id
    );
endinterface

// File: rtl/irq_front_ctrl.sv
// Interrupt front-end: synchronizer, edge/level pending capture,
// in-service tracking and single highest-priority request.
module irq_front_ctrl #(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] edge_sel,
    input  logic [N_IRQ-1:0] mask,
    input  logic             nest_en,
    input  logic [N_IRQ-1:0] sw_clr,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] overflow,
    irq_front_ctrl_if.slave  bus
);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [N_IRQ-1:0] ovf_q, ovf_d;

    logic [N_IRQ-1:0] lvl;
    logic [N_IRQ-1:0] ev;
    logic [N_IRQ-1:0] pend_eff;
    logic [N_IRQ-1:0] isr_low;
    logic [N_IRQ-1:0] gate;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] req;
    logic [N_IRQ-1:0] acked;
    logic [IDW-1:0]   id;
    logic             valid;
    logic             ack_fire;

    assign lvl = sync_q[SYNC_STAGES-1];
    assign ev  = lvl & ~prev_q & edge_sel;

    // Level lines are not latched: they track the synchronized input.
    assign pend_eff = (edge_sel & pend_q) | (~edge_sel & lvl & ~isr_q);

    // isr_low-1 is all ones when nothing is in service.
    assign isr_low = isr_q & (~isr_q + 1'b1);
    assign gate    = (nest_en || isr_q == '0) ? (isr_low - 1'b1) : '0;
    assign elig    = pend_eff & mask & ~isr_q & gate;
    assign req     = elig & (~elig + 1'b1);
    assign valid   = |elig;

    always_comb begin
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) id = IDW'(i);
        end
    end

    assign ack_fire = bus.ack & valid;
    assign acked    = ack_fire ? req : '0;

    always_comb begin
        isr_d = isr_q;
        if (bus.eoi) isr_d = isr_d & ~isr_low;
        isr_d = isr_d | acked;
    end

    always_comb begin
        pend_d = (pend_q & ~sw_clr & ~acked) | ev;
        pend_d = pend_d & edge_sel;
        ovf_d  = (ovf_q | (ev & pend_q & ~acked)) & ~sw_clr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
            pend_q <= '0;
            isr_q  <= '0;
            ovf_q  <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= lvl;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pending       = pend_eff;
    assign in_service    = isr_q;
    assign overflow      = ovf_q;
    assign bus.irq_req   = req;
    assign bus.irq_valid = valid;
    assign bus.irq_id    = id;

endmodule

// File: tb/tb_irq_front_ctrl.sv
// Directed bench for irq_front_ctrl; expected values are hand-derived.
module tb_irq_front_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] irq_in, edge_sel, mask, sw_clr;
    logic       nest_en;
    logic [7:0] pending, in_service, overflow;
    int         total = 0;
    int         bad = 0;

    irq_front_ctrl_if #(.N_IRQ(8)) bus ();

    irq_front_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .irq_in     (irq_in),
        .edge_sel   (edge_sel),
        .mask       (mask),
        .nest_en    (nest_en),
        .sw_clr     (sw_clr),
        .pending    (pending),
        .in_service (in_service),
        .overflow   (overflow),
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_ack;
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
    endtask

    task automatic do_eoi;
        bus.eoi = 1'b1;
        cyc(1);
        bus.eoi = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        irq_in = '0;
        edge_sel = 8'hFE;
        mask = 8'hFF;
        sw_clr = '0;
        nest_en = 1'b1;
        bus.ack = 1'b0;
        bus.eoi = 1'b0;
        cyc(2);
        chk("rst_pend", pending, 0);
        chk("rst_isr", in_service, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_req", bus.irq_req, 0);
        chk("rst_valid", bus.irq_valid, 0);
        chk("rst_id", bus.irq_id, 0);
        RST = 1'b0;
        cyc(1);
        do_ack;
        chk("ack_idle", in_service, 0);

        // 1: edge line 3
        irq_in[3] = 1'b1;
        cyc(2);
        chk("t1_pend_early", pending, 0);
        cyc(1);
        chk("t1_pend", pending, 8'h08);
        chk("t1_req", bus.irq_req, 8'h08);
        chk("t1_id", bus.irq_id, 3);
        do_ack;
        chk("t1_isr", in_service, 8'h08);
        chk("t1_pend_clr", pending, 0);
        chk("t1_valid", bus.irq_valid, 0);
        do_eoi;
        chk("t1_eoi", in_service, 0);
        irq_in[3] = 1'b0;
        cyc(3);

        // 2: lines 5 and 2 together
        irq_in[5] = 1'b1;
        irq_in[2] = 1'b1;
        cyc(3);
        chk("t2_pend", pending, 8'h24);
        chk("t2_id", bus.irq_id, 2);
        do_ack;
        chk("t2_isr", in_service, 8'h04);
        chk("t2_held", bus.irq_valid, 0);
        do_eoi;
        chk("t2_id5", bus.irq_id, 5);
        chk("t2_req5", bus.irq_req, 8'h20);
        do_ack;
        do_eoi;
        chk("t2_done", in_service | pending, 0);
        irq_in = '0;
        cyc(3);

        // 3: nesting over line 4
        irq_in[4] = 1'b1;
        cyc(3);
        do_ack;
        chk("t3_isr4", in_service, 8'h10);
        irq_in[1] = 1'b1;
        cyc(3);
        chk("t3_nest_req", bus.irq_req, 8'h02);
        do_ack;
        irq_in[1] = 1'b0;
        chk("t3_isr12", in_service, 8'h12);
        do_eoi;
        chk("t3_eoi", in_service, 8'h10);
        cyc(2);
        nest_en = 1'b0;
        irq_in[1] = 1'b1;
        cyc(3);
        chk("t3_pend1", pending, 8'h02);
        chk("t3_nonest", bus.irq_valid, 0);
        do_eoi;
        chk("t3_valid_after", bus.irq_valid, 1);
        chk("t3_id1", bus.irq_id, 1);
        do_ack;
        do_eoi;
        chk("t3_done", in_service, 0);
        irq_in = '0;
        nest_en = 1'b1;
        cyc(3);

        // 4: level line 0
        irq_in[0] = 1'b1;
        cyc(2);
        chk("t4_req", bus.irq_req, 8'h01);
        chk("t4_pend", pending, 8'h01);
        do_ack;
        chk("t4_isr", in_service, 8'h01);
        chk("t4_valid", bus.irq_valid, 0);
        chk("t4_pend_mask", pending, 0);
        do_eoi;
        chk("t4_reappear", bus.irq_valid, 1);
        irq_in[0] = 1'b0;
        cyc(1);
        chk("t4_drop1", bus.irq_valid, 1);
        cyc(1);
        chk("t4_drop2", bus.irq_valid, 0);
        cyc(2);

        // 5: edge line 6 overflow and sw_clr
        irq_in[6] = 1'b1;
        cyc(3);
        chk("t5_pend", pending, 8'h40);
        chk("t5_ovf0", overflow, 0);
        irq_in[6] = 1'b0;
        cyc(3);
        irq_in[6] = 1'b1;
        cyc(3);
        chk("t5_ovf", overflow, 8'h40);
        chk("t5_pend2", pending, 8'h40);
        mask = 8'hBF;
        #1;
        chk("t5_masked", bus.irq_valid, 0);
        chk("t5_mask_keep", pending, 8'h40);
        mask = 8'hFF;
        sw_clr = 8'h40;
        cyc(1);
        sw_clr = '0;
        chk("t5_clr_pend", pending, 0);
        chk("t5_clr_ovf", overflow, 0);
        irq_in[6] = 1'b0;
        cyc(3);
        irq_in[6] = 1'b1;
        cyc(2);
        sw_clr = 8'h40;
        cyc(1);
        sw_clr = '0;
        chk("t5_coin_pend", pending, 8'h40);
        chk("t5_coin_ovf", overflow, 0);
        irq_in[6] = 1'b0;
        cyc(3);
        irq_in[6] = 1'b1;
        cyc(2);
        do_ack;
        chk("t5_ackev_isr", in_service, 8'h40);
        chk("t5_ackev_pend", pending, 8'h40);
        chk("t5_ackev_ovf", overflow, 0);
        do_eoi;
        do_ack;
        chk("t5_ack2_pend", pending, 0);
        do_eoi;
        irq_in = '0;
        cyc(3);

        // 6: reset mid-service
        irq_in[1] = 1'b1;
        cyc(3);
        do_ack;
        irq_in[0] = 1'b1;
        cyc(2);
        chk("t6_id0", bus.irq_id, 0);
        do_ack;
        irq_in[7] = 1'b1;
        cyc(3);
        chk("t6_isr", in_service, 8'h03);
        chk("t6_pend", pending, 8'h80);
        RST = 1'b1;
        irq_in = 8'h80;
        cyc(1);
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_isr", in_service, 0);
        chk("t6_rst_valid", bus.irq_valid, 0);
        chk("t6_rst_id", bus.irq_id, 0);
        cyc(1);
        RST = 1'b0;
        cyc(2);
        chk("t6_rel_early", pending, 0);
        cyc(1);
        chk("t6_rel_pend", pending, 8'h80);
        chk("t6_rel_id", bus.irq_id, 7);
        cyc(4);
        chk("t6_once_pend", pending, 8'h80);
        chk("t6_once_ovf", overflow, 0);
        do_ack;
        cyc(3);
        chk("t6_final_pend", pending, 0);
        chk("t6_final_isr", in_service, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
